// File: rtl/pattern_to_sensors.sv
// Pattern bridge: pops 256-bit words, emits four 64-bit beats MSB first, optionally plays eight 20-bit samples.
// Optional word counter output enabled by defining PTS_WORD_COUNT_EN.
module pattern_to_sensors #(
    parameter int IN_W   = 256,
    parameter int OUT_W  = 64,
    parameter int SLOT_W = 32,
    parameter int SAMP_W = 20,
    parameter int NPAT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPAT_W-1:0] Num_Pat,
    input  logic              stream_en_i,
    output logic              stream_en_o,
    output logic [SAMP_W-1:0] MSTREAMOUT,
    input  logic [IN_W-1:0]   MSTREAM32,
    input  logic              empty,
    input  logic              valid,
    output logic              rd_en,
    output logic [OUT_W-1:0]  DO,
    output logic              valid_fifo
`ifdef PTS_WORD_COUNT_EN
    ,
    output logic [31:0]       word_cnt
`endif
);

    localparam int NBEATS     = IN_W / OUT_W;
    localparam int NSLOTS     = IN_W / SLOT_W;
    localparam int BEAT_W     = $clog2(NBEATS);
    localparam int SLOT_IDX_W = $clog2(NSLOTS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_EMIT,
        ST_PLAY
    } state_t;

    state_t                state_q, state_d;
    logic [IN_W-1:0]       word_q, word_d;
    logic                  strm_q, strm_d;
    logic                  rd_en_q, rd_en_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [OUT_W-1:0]      do_q, do_d;
    logic [SLOT_IDX_W-1:0] samp_q, samp_d;
    logic [NPAT_W-1:0]     hold_q, hold_d;
    logic [NPAT_W-1:0]     npat_q, npat_d;
    logic [OUT_W-1:0]      cur_beat;
    logic [SAMP_W-1:0]     cur_samp;
    logic                  capture;

    assign capture = (state_q == ST_WAIT) && valid;
    assign rd_en   = rd_en_q;

    always_comb begin
        cur_beat = '0;
        for (int b = 0; b < NBEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
                cur_beat = word_q[IN_W-1-b*OUT_W -: OUT_W];
            end
        end
    end

    // Sample k lives in the low SAMP_W bits of slot k, slots counted from the MSB end.
    always_comb begin
        cur_samp = '0;
        for (int s = 0; s < NSLOTS; s++) begin
            if (samp_q == SLOT_IDX_W'(s)) begin
                cur_samp = word_q[IN_W-1-s*SLOT_W-(SLOT_W-SAMP_W) -: SAMP_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        strm_d      = strm_q;
        rd_en_d     = 1'b0;
        beat_d      = beat_q;
        do_d        = do_q;
        samp_d      = samp_q;
        hold_d      = hold_q;
        npat_d      = npat_q;
        valid_fifo  = 1'b0;
        DO          = do_q;
        stream_en_o = 1'b0;
        MSTREAMOUT  = '0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    rd_en_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (capture) begin
                    word_d  = MSTREAM32;
                    strm_d  = stream_en_i;
                    beat_d  = '0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                valid_fifo = 1'b1;
                DO         = cur_beat;
                do_d       = cur_beat;
                beat_d     = beat_q + 1'b1;
                if (beat_q == BEAT_W'(NBEATS-1)) begin
                    state_d = strm_q ? ST_PLAY : ST_IDLE;
                    npat_d  = (Num_Pat == '0) ? NPAT_W'(1) : Num_Pat;
                    samp_d  = '0;
                    hold_d  = '0;
                end
            end
            ST_PLAY: begin
                stream_en_o = 1'b1;
                MSTREAMOUT  = cur_samp;
                if (hold_q == npat_q - NPAT_W'(1)) begin
                    hold_d = '0;
                    samp_d = samp_q + 1'b1;
                    if (samp_q == SLOT_IDX_W'(NSLOTS-1)) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            strm_q  <= 1'b0;
            rd_en_q <= 1'b0;
            beat_q  <= '0;
            do_q    <= '0;
            samp_q  <= '0;
            hold_q  <= '0;
            npat_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            strm_q  <= strm_d;
            rd_en_q <= rd_en_d;
            beat_q  <= beat_d;
            do_q    <= do_d;
            samp_q  <= samp_d;
            hold_q  <= hold_d;
            npat_q  <= npat_d;
        end
    end

`ifdef PTS_WORD_COUNT_EN
    logic [31:0] word_cnt_q, word_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (capture) begin
            word_cnt_d = word_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_pattern_to_sensors.sv
// Self-checking bench for pattern_to_sensors: input FIFO model, output scoreboard, table and random stimulus.
module tb_pattern_to_sensors;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   Num_Pat;
    logic         stream_en_i;
    logic         stream_en_o;
    logic [19:0]  MSTREAMOUT;
    logic [255:0] MSTREAM32;
    logic         empty;
    logic         valid;
    logic         rd_en;
    logic [63:0]  DO;
    logic         valid_fifo;

    always #5 clk = ~clk;

    pattern_to_sensors dut (
        .clk         (clk),
        .reset       (reset),
        .Num_Pat     (Num_Pat),
        .stream_en_i (stream_en_i),
        .stream_en_o (stream_en_o),
        .MSTREAMOUT  (MSTREAMOUT),
        .MSTREAM32   (MSTREAM32),
        .empty       (empty),
        .valid       (valid),
        .rd_en       (rd_en),
        .DO          (DO),
        .valid_fifo  (valid_fifo)
    );

    localparam logic [255:0] W0 = 256'h000fffff_000eeeee_000ddddd_000ccccc_000bbbbb_000aaaaa_00099999_00088888;
    localparam logic [255:0] W1 = 256'h00077777_00066666_00055555_00044444_00033333_00022222_00011111_00000000;
    localparam logic [255:0] W2 = 256'hABC12345_ABC12345_ABC12345_ABC12345_ABC12345_ABC12345_ABC12345_ABC12345;
    localparam logic [255:0] W3 = 256'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0_DEADBEEF_CAFEF00D_00000001_80000000;

    typedef struct {
        logic [255:0] word;
        bit           strm;
        logic [7:0]   npat;
        logic [63:0]  beat0;
        logic [63:0]  beat3;
        int           playCycles;
        logic [19:0]  samp0;
    } vec_t;

    vec_t tbl[6];

    logic [255:0] inQ[$];
    logic [63:0]  expBeats[$];
    logic [63:0]  actBeats[$];
    logic [19:0]  expSamps[$];
    logic [19:0]  actSamps[$];

    int vectors      = 0;
    int miscompares  = 0;
    int rdCount      = 0;
    int rdWhileEmpty = 0;

    // Standard (non-FWFT) input FIFO: a read strobe seen in one cycle yields dout/valid in the next.
    initial begin
        logic rdSeen;
        valid     = 1'b0;
        empty     = 1'b1;
        MSTREAM32 = '0;
        forever begin
            @(negedge clk);
            rdSeen = rd_en;
            @(posedge clk);
            #1;
            if (rdSeen === 1'b1 && inQ.size() > 0) begin
                MSTREAM32 = inQ.pop_front();
                valid     = 1'b1;
            end else begin
                valid = 1'b0;
            end
            empty = (inQ.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (valid_fifo === 1'b1) actBeats.push_back(DO);
            if (stream_en_o === 1'b1) actSamps.push_back(MSTREAMOUT);
            if (rd_en === 1'b1) rdCount++;
            if (rd_en === 1'b1 && empty === 1'b1) rdWhileEmpty++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference: beats are the word cut into 64-bit pieces from the top; each sample is the low 20 bits of a 32-bit slot.
    task automatic modelWord(input logic [255:0] w, input bit strm, input logic [7:0] np);
        logic [255:0] t;
        logic [31:0]  slot;
        int           reps;
        for (int b = 0; b < 4; b++) begin
            t = w >> (64 * (3 - b));
            expBeats.push_back(t[63:0]);
        end
        if (strm) begin
            reps = (np == 0) ? 1 : int'(np);
            for (int k = 0; k < 8; k++) begin
                t    = w >> (32 * (7 - k));
                slot = t[31:0];
                for (int r = 0; r < reps; r++) expSamps.push_back(slot[19:0]);
            end
        end
    endtask

    task automatic applyStimulus(input logic [255:0] w, input bit strm, input logic [7:0] np);
        stream_en_i = strm;
        Num_Pat     = np;
        modelWord(w, strm, np);
        inQ.push_back(w);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((actBeats.size() < expBeats.size() || actSamps.size() < expSamps.size()) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s timeout: got %0d beats %0d samples expected %0d beats %0d samples",
                     name, actBeats.size(), actSamps.size(), expBeats.size(), expSamps.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic compareQueues(input string name);
        checkOutput({name, " beat count"}, 64'(actBeats.size()), 64'(expBeats.size()));
        checkOutput({name, " sample count"}, 64'(actSamps.size()), 64'(expSamps.size()));
        while (actBeats.size() > 0 && expBeats.size() > 0)
            checkOutput({name, " beat"}, actBeats.pop_front(), expBeats.pop_front());
        while (actSamps.size() > 0 && expSamps.size() > 0)
            checkOutput({name, " sample"}, 64'(actSamps.pop_front()), 64'(expSamps.pop_front()));
        actBeats.delete();
        expBeats.delete();
        actSamps.delete();
        expSamps.delete();
    endtask

    initial begin
        logic [31:0]  host[32];
        logic [255:0] w;
        int           n;
        int           lat;

        tbl[0] = '{W0, 1'b0, 8'd0, 64'h000fffff_000eeeee, 64'h00099999_00088888, 0,  20'h00000};
        tbl[1] = '{W1, 1'b0, 8'd0, 64'h00077777_00066666, 64'h00011111_00000000, 0,  20'h00000};
        tbl[2] = '{W0, 1'b1, 8'd2, 64'h000fffff_000eeeee, 64'h00099999_00088888, 16, 20'hfffff};
        tbl[3] = '{W1, 1'b1, 8'd0, 64'h00077777_00066666, 64'h00011111_00000000, 8,  20'h77777};
        tbl[4] = '{W2, 1'b1, 8'd1, 64'hABC12345_ABC12345, 64'hABC12345_ABC12345, 8,  20'h12345};
        tbl[5] = '{W3, 1'b1, 8'd3, 64'h12345678_9ABCDEF0, 64'h00000001_80000000, 24, 20'h45678};

        reset       = 1'b0;
        Num_Pat     = 8'd0;
        stream_en_i = 1'b0;
        #50;
        checkOutput("reset rd_en", 64'(rd_en), 64'd0);
        checkOutput("reset valid_fifo", 64'(valid_fifo), 64'd0);
        checkOutput("reset DO", DO, 64'd0);
        checkOutput("reset MSTREAMOUT", 64'(MSTREAMOUT), 64'd0);
        checkOutput("reset stream_en_o", 64'(stream_en_o), 64'd0);
        #50;
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("idle empty rd_en pulses", 64'(rdCount), 64'd0);
        checkOutput("idle valid_fifo", 64'(valid_fifo), 64'd0);
        checkOutput("idle DO", DO, 64'd0);

        // First-beat latency measured from the first cycle the FIFO reports non-empty.
        applyStimulus(W0, 1'b0, 8'd0);
        n = 0;
        while (empty !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        lat = 0;
        while (valid_fifo !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("first beat latency", 64'(lat), 64'd3);
        waitDrain("latency");
        compareQueues("latency");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].word, tbl[i].strm, tbl[i].npat);
            waitDrain("table");
            if (actBeats.size() >= 4) begin
                checkOutput($sformatf("table%0d beat0", i), actBeats[0], tbl[i].beat0);
                checkOutput($sformatf("table%0d beat3", i), actBeats[3], tbl[i].beat3);
            end else begin
                checkOutput($sformatf("table%0d beats", i), 64'(actBeats.size()), 64'd4);
            end
            checkOutput($sformatf("table%0d play cycles", i), 64'(actSamps.size()), 64'(tbl[i].playCycles));
            if (tbl[i].playCycles > 0 && actSamps.size() > 0)
                checkOutput($sformatf("table%0d sample0", i), 64'(actSamps[0]), 64'(tbl[i].samp0));
            compareQueues($sformatf("table%0d", i));
        end

        // 32-word host burst must come back out of the beats in write order.
        for (int i = 0; i < 16; i++) host[i] = 32'(15 - i) * 32'h00011111;
        for (int i = 16; i < 31; i++) host[i] = 32'(i - 15) * 32'h00011111;
        host[31] = 32'h000eeeee;
        for (int j = 0; j < 4; j++) begin
            w = '0;
            for (int s = 0; s < 8; s++) w = (w << 32) | 256'(host[8*j+s]);
            applyStimulus(w, 1'b0, 8'd0);
        end
        waitDrain("burst");
        checkOutput("burst valid_fifo pulses", 64'(actBeats.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < actBeats.size()) begin
                checkOutput($sformatf("burst host%0d", 2*i), 64'(actBeats[i][63:32]), 64'(host[2*i]));
                checkOutput($sformatf("burst host%0d", 2*i+1), 64'(actBeats[i][31:0]), 64'(host[2*i+1]));
            end
        end
        compareQueues("burst");

        // Num_Pat changed mid-play must not affect the word already playing.
        applyStimulus(W3, 1'b1, 8'd3);
        n = 0;
        while (stream_en_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        Num_Pat = 8'd1;
        waitDrain("numpat change");
        compareQueues("numpat change");

        // Reset while beat2 is on DO.
        stream_en_i = 1'b0;
        Num_Pat     = 8'd0;
        inQ.push_back(W0);
        n = 0;
        while (valid_fifo !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre-reset beat2", DO, 64'h000bbbbb_000aaaaa);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid reset valid_fifo", 64'(valid_fifo), 64'd0);
        checkOutput("mid reset DO", DO, 64'd0);
        checkOutput("mid reset rd_en", 64'(rd_en), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        actBeats.delete();
        actSamps.delete();
        expBeats.delete();
        expSamps.delete();
        repeat (10) @(negedge clk);
        checkOutput("beats after reset", 64'(actBeats.size()), 64'd0);
        applyStimulus(W1, 1'b0, 8'd0);
        waitDrain("post reset");
        if (actBeats.size() > 0)
            checkOutput("post reset beat0", actBeats[0], 64'h00077777_00066666);
        compareQueues("post reset");

        for (int r = 0; r < 24; r++) begin
            w = '0;
            for (int s = 0; s < 8; s++) w = (w << 32) | 256'($urandom);
            applyStimulus(w, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)));
            waitDrain("random");
            compareQueues($sformatf("random%0d", r));
        end

        // Back-to-back streaming words: playback must finish before the next word is read.
        stream_en_i = 1'b1;
        Num_Pat     = 8'd2;
        for (int r = 0; r < 3; r++) begin
            w = '0;
            for (int s = 0; s < 8; s++) w = (w << 32) | 256'($urandom);
            modelWord(w, 1'b1, 8'd2);
            inQ.push_back(w);
        end
        waitDrain("stream burst");
        compareQueues("stream burst");

        checkOutput("rd_en while empty", 64'(rdWhileEmpty), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
